fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end placed directly upstream of the core. Owns the fetch PC, issues word-aligned requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses, and buffers returned instructions in a small FIFO. Presents `instr`/`instr_pc` to the core with a valid/ready handshake. On a core redirect (branch/jump), flushes the buffer and discards in-flight responses.

## Interface
- `DEPTH`, 4: FIFO entries and maximum in-flight plus buffered fetches; power of 2, ≥2
- `RESET_PC`, 32'h0000_0000: first fetch address after reset
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `redirect_valid`  in  1  core requests a PC change this cycle
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored and forced to 0
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_addr`  out  32  fetch address, word aligned
- `imem_req_ready`  in  1  memory accepts the request
- `imem_rsp_valid`  in  1  response data valid; responses return in request order
- `imem_rsp_data`  in  32  instruction word
- `instr_valid`  out  1  `instr`/`instr_pc` valid
- `instr`  out  32  instruction to core; 32'h0000_0013 (NOP) when `instr_valid`=0
- `instr_pc`  out  32  address of `instr`; 0 when `instr_valid`=0
- `instr_ready`  in  1  core consumes the head instruction

## Operation
- State: `fetch_pc` (next request address), `rsp_pc` (address of next kept response), `outstanding` (accepted requests awaiting response), `drop_cnt` (in-flight responses to discard), and FIFO of {pc, instr}. Counters are clog2(DEPTH)+1 bits wide.
- Issue: `imem_req_valid` = !redirect_valid && (outstanding + fifo_count < DEPTH); `imem_req_addr` = `fetch_pc`. Both use registered values.
- Request accept: on valid&&ready, `fetch_pc` += 4 (wraps at 2^32) and `outstanding` increments.
- Request stability: once asserted, valid and address hold until accepted. The only exception is a redirect, which withdraws the request.
- Response with `drop_cnt`>0: discarded; `drop_cnt` and `outstanding` decrement.
- Response with `drop_cnt`=0: {rsp_pc, data} pushed to the FIFO; `rsp_pc` += 4; `outstanding` decrements. The credit rule guarantees no overflow.
- Consume: on instr_valid&&instr_ready, pop the head.
- Redirect cycle, registered effects:
  - `fetch_pc` and `rsp_pc` ← redirect_pc & ~3
  - FIFO flushed
  - `drop_cnt` ← `outstanding` − `imem_rsp_valid`
  - `outstanding` ← `outstanding` − `imem_rsp_valid`
- Redirect cycle, same-cycle events:
  - A response arriving in this cycle is dropped.
  - An `instr_ready` pop is ignored.
  - No request is issued.
- Simultaneous accept and response: `outstanding` unchanged.
- Simultaneous push and pop: FIFO count unchanged; a full FIFO may push and pop in the same cycle.
- Reset values (rst_n=0 at edge): `fetch_pc`=`rsp_pc`=RESET_PC; all counters 0; FIFO empty; `imem_req_valid`=0 while rst_n=0; `instr_valid`=0.
- Reset mid-operation clears all in-flight tracking. The memory model must be reset on the same `rst_n`; responses after reset release for pre-reset requests are illegal.

## Timing
- Request issued the first cycle after reset release.
- With 1-cycle memory: request accepted in cycle N, response in N+1, `instr_valid` in N+2 (registered FIFO).
- Redirect in cycle R: first request to `redirect_pc` in R+1.
- Steady-state throughput: one instruction per cycle when memory accepts every cycle, `instr_ready`=1, and DEPTH ≥ memory latency+1.
- No combinational path from `imem_rsp_*` to `instr_*` unless the bypass feature (below) is enabled.
- `imem_req_valid` depends combinationally on `redirect_valid`.

## Configuration
- `FETCH_BYPASS_EN` defined: when the FIFO is empty and a kept response arrives, it drives `instr_valid`/`instr`/`instr_pc` in the same cycle. It is pushed only if `instr_ready`=0. Latency in the example above becomes N+1.
- Not defined: all instructions pass through FIFO registers; minimum response-to-`instr_valid` latency is one cycle.

## Structure
- Package `fetch_pkg`:
  - `NOP_INSTR`=32'h0000_0013
  - `RESET_PC_DEFAULT`
  - typedef `fetch_entry_t` {pc[31:0], instr[31:0]}
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, parameter DEPTH, with push/pop/flush, count, full, and empty outputs. Flush has priority over push and pop.

## Test plan
- Reset release, 1-cycle memory, `instr_ready`=1 → `imem_req_addr` 0,4,8,… on consecutive cycles; `instr_pc` 0 appears two cycles after the first accept, then one instruction per cycle.
- `imem_req_ready`=0 for 5 cycles → `imem_req_addr` holds at 0x8 and valid stays high; sequence resumes without gaps or duplicates.
- `instr_ready`=0 with DEPTH=4 → exactly 4 requests accepted, then `imem_req_valid`=0; releasing ready drains PCs 0,4,8,C in order.
- 3-cycle memory, redirect to 0x103 with 2 responses in flight → both dropped; next request and first `instr_pc` are 0x100.
- Redirect in the same cycle as a response and a pop → response dropped, FIFO empty next cycle, `drop_cnt` = remaining outstanding.
- Assert `rst_n`=0 mid-stream for one cycle → `instr_valid`=0, `instr`=0x00000013, first request at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch front end.
package fetch_pkg;

    // Encoding of "addi x0, x0, 0", presented when no instruction is valid.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered fetch result: where it came from and what was read.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Instruction addresses are always word aligned; low bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop and flush.
// Flush wins over push and pop. A full FIFO may push when it pops in the same
// cycle. Storage is not reset; only the pointers and the count are.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_push_data,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count,
    output logic         o_full,
    output logic         o_empty
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy tracking; flush empties the FIFO outright.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; written only by a push that is not overridden by flush.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Owns the fetch PC, issues word
// aligned requests to instruction memory, buffers in-order responses in a
// small FIFO and hands {instr, instr_pc} to the core.
//
// Handshakes: a transfer happens on a channel in any cycle where valid and
// ready are both high at the rising edge; once valid is raised, valid and
// payload hold until that transfer, except that a redirect withdraws a fetch
// request.
//
// Optional build macro FETCH_BYPASS_EN: a kept response arriving while the
// FIFO is empty is shown to the core in the same cycle, and is only buffered
// if the core does not take it. Without the macro every instruction passes
// through the FIFO registers.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;

    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_unused_fifo_full;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;
    logic          w_push;
    logic          w_pop;
    logic          w_req_fire;
    logic          w_rsp_keep;
    logic          w_rsp_drop;
    logic [CW:0]   w_inflight;
    logic          w_credit_ok;

    // Every accepted request owns a future FIFO slot, so in-flight plus
    // buffered fetches are capped at DEPTH and a kept response always fits.
    assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_credit_ok    = (w_inflight < (CW + 1)'(DEPTH));
    assign imem_req_valid = rst_n && !redirect_valid && w_credit_ok;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Responses that belong to requests issued before a redirect are dropped,
    // as is any response landing in the redirect cycle itself.
    assign w_rsp_keep  = imem_rsp_valid && !redirect_valid && (r_drop_cnt == '0);
    assign w_rsp_drop  = imem_rsp_valid && !redirect_valid && (r_drop_cnt != '0);
    assign w_push_data = '{pc: r_rsp_pc, instr: imem_rsp_data};

    // The credit rule already prevents overflow; full is kept for observability.
    assign w_unused_fifo_full = w_fifo_full;

`ifdef FETCH_BYPASS_EN
    logic w_bypass;

    assign w_bypass    = w_fifo_empty && w_rsp_keep;
    assign w_push      = w_rsp_keep && !(w_bypass && instr_ready);
    assign w_pop       = !w_fifo_empty && instr_ready && !redirect_valid;
    assign instr_valid = !w_fifo_empty || w_bypass;
    assign instr       = !w_fifo_empty ? w_head.instr :
                         (w_bypass ? imem_rsp_data : NOP_INSTR);
    assign instr_pc    = !w_fifo_empty ? w_head.pc :
                         (w_bypass ? r_rsp_pc : 32'h0000_0000);
`else
    assign w_push      = w_rsp_keep;
    assign w_pop       = !w_fifo_empty && instr_ready && !redirect_valid;
    assign instr_valid = !w_fifo_empty;
    assign instr       = w_fifo_empty ? NOP_INSTR : w_head.instr;
    assign instr_pc    = w_fifo_empty ? 32'h0000_0000 : w_head.pc;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .i_push_data (w_push_data),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // PC and in-flight bookkeeping; a redirect restarts both PCs and marks
    // every response still owed by memory for discard.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= word_align(redirect_pc);
            r_rsp_pc      <= word_align(redirect_pc);
            r_outstanding <= r_outstanding - {{(CW - 1){1'b0}}, imem_rsp_valid};
            r_drop_cnt    <= r_outstanding - {{(CW - 1){1'b0}}, imem_rsp_valid};
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_rsp_keep) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
            end
            if (w_rsp_drop) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            case ({w_req_fire, imem_rsp_valid})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (default build, DEPTH=4,
// RESET_PC=0). A small in-order memory model with programmable latency
// answers every accepted request with a word derived from its address.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    // ---- clock ----
    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    // ---- memory model ----
    int          mem_lat = 1;
    int          cyc_n = 0;
    int          accept_cnt = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    // Present the oldest response once its latency has elapsed.
    always begin
        @(posedge clk);
        cyc_n = cyc_n + 1;
        #1;
        if (mq_addr.size() != 0 && mq_due[0] <= cyc_n) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mq_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // Record handshakes mid-cycle, when all inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq_addr.delete();
            mq_due.delete();
            accept_cnt = 0;
        end else begin
            if (imem_rsp_valid) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(cyc_n + mem_lat);
                accept_cnt = accept_cnt + 1;
            end
        end
    end

    // ---- driver tasks ----
    // Drive one cycle's inputs shortly after the rising edge, then settle.
    task automatic cyc(input logic rst, input logic core_rdy, input logic mem_rdy,
                       input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #2;
        rst_n          = rst;
        instr_ready    = core_rdy;
        imem_req_ready = mem_rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic run();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic do_reset(input logic core_rdy);
        cyc(1'b0, core_rdy, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, core_rdy, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert = n_assert + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---- directed sequence ----
    initial begin
        // Reset state
        do_reset(1'b1);
        chk("rst_req_valid",   32'(imem_req_valid), 32'h0);
        chk("rst_instr_valid", 32'(instr_valid),    32'h0);
        chk("rst_instr",       instr,               32'h0000_0013);
        chk("rst_instr_pc",    instr_pc,            32'h0);

        // Streaming with 1-cycle memory
        for (int k = 0; k < 6; k++) begin
            run();
            chk("s1_req_valid", 32'(imem_req_valid), 32'h1);
            chk("s1_req_addr",  imem_req_addr,       32'(4 * k));
            if (k >= 2) begin
                chk("s1_instr_valid", 32'(instr_valid), 32'h1);
                chk("s1_instr_pc",    instr_pc,         32'(4 * (k - 2)));
                chk("s1_instr",       instr,            mem_data(32'(4 * (k - 2))));
            end
        end

        // Memory stalls for 5 cycles while addr 0x8 is pending
        mem_lat = 1;
        do_reset(1'b1);
        run();
        chk("s2_addr_c0", imem_req_addr, 32'h0);
        run();
        chk("s2_addr_c1", imem_req_addr, 32'h4);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("s2_hold_valid", 32'(imem_req_valid), 32'h1);
            chk("s2_hold_addr",  imem_req_addr,       32'h8);
            if (i == 0) chk("s2_pc0", instr_pc, 32'h0);
            if (i == 1) chk("s2_pc4", instr_pc, 32'h4);
            if (i == 2) chk("s2_gap_valid", 32'(instr_valid), 32'h0);
        end
        run();
        chk("s2_resume_addr", imem_req_addr, 32'h8);
        run();
        chk("s2_next_addr",   imem_req_addr,     32'hC);
        chk("s2_not_yet",     32'(instr_valid),  32'h0);
        run();
        chk("s2_pc8",    instr_pc,      32'h8);
        chk("s2_addr10", imem_req_addr, 32'h10);
        run();
        chk("s2_pcC",    instr_pc,      32'hC);

        // Core stalled: credit limit of 4, then ordered drain
        mem_lat = 1;
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("s3_fill_valid", 32'(imem_req_valid), 32'h1);
            chk("s3_fill_addr",  imem_req_addr,       32'(4 * k));
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("s3_stop_valid", 32'(imem_req_valid), 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("s3_stop_valid2", 32'(imem_req_valid), 32'h0);
        chk("s3_accepts",     32'(accept_cnt),     32'd4);
        chk("s3_head_valid",  32'(instr_valid),    32'h1);
        chk("s3_head_pc",     instr_pc,            32'h0);
        run();
        chk("s3_drain_pc0",   instr_pc,            32'h0);
        chk("s3_still_full",  32'(imem_req_valid), 32'h0);
        run();
        chk("s3_drain_pc4",   instr_pc,            32'h4);
        chk("s3_refill_addr", imem_req_addr,       32'h10);
        run();
        chk("s3_drain_pc8",   instr_pc,            32'h8);
        run();
        chk("s3_drain_pcC",   instr_pc,            32'hC);

        // 3-cycle memory, redirect to 0x103 with two responses in flight
        mem_lat = 3;
        do_reset(1'b1);
        run();
        chk("s4_addr0", imem_req_addr, 32'h0);
        run();
        chk("s4_addr4", imem_req_addr, 32'h4);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
        chk("s4_redir_req_valid", 32'(imem_req_valid), 32'h0);
        run();
        chk("s4_new_valid", 32'(imem_req_valid),   32'h1);
        chk("s4_new_addr",  imem_req_addr,         32'h100);
        chk("s4_drop2",     32'(dut.r_drop_cnt),   32'd2);
        run();
        chk("s4_drop1",     32'(dut.r_drop_cnt),   32'd1);
        chk("s4_empty_c4",  32'(instr_valid),      32'h0);
        run();
        chk("s4_drop0",     32'(dut.r_drop_cnt),   32'd0);
        chk("s4_empty_c5",  32'(instr_valid),      32'h0);
        run();
        chk("s4_empty_c6",  32'(instr_valid),      32'h0);
        run();
        chk("s4_first_pc",  instr_pc,              32'h100);
        chk("s4_first_ins", instr,                 mem_data(32'h100));
        run();
        chk("s4_second_pc", instr_pc,              32'h104);

        // Redirect coinciding with a response and a core pop
        mem_lat = 2;
        do_reset(1'b1);
        run();
        run();
        run();
        chk("s5_addr8", imem_req_addr, 32'h8);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        chk("s5_rsp_here",    32'(imem_rsp_valid), 32'h1);
        chk("s5_head_pc",     instr_pc,            32'h0);
        chk("s5_req_blocked", 32'(imem_req_valid), 32'h0);
        run();
        chk("s5_flushed",     32'(instr_valid),       32'h0);
        chk("s5_drop",        32'(dut.r_drop_cnt),    32'd1);
        chk("s5_outstanding", 32'(dut.r_outstanding), 32'd1);
        chk("s5_new_addr",    imem_req_addr,          32'h200);
        run();
        chk("s5_drop_done",   32'(dut.r_drop_cnt),    32'd0);
        chk("s5_empty_c5",    32'(instr_valid),       32'h0);
        run();
        chk("s5_empty_c6",    32'(instr_valid),       32'h0);
        run();
        chk("s5_first_pc",    instr_pc,               32'h200);

        // One-cycle reset in the middle of the stream
        run();
        mem_lat = 1;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("s6_rst_req_valid", 32'(imem_req_valid), 32'h0);
        run();
        chk("s6_instr_valid", 32'(instr_valid),    32'h0);
        chk("s6_instr_nop",   instr,               32'h0000_0013);
        chk("s6_instr_pc",    instr_pc,            32'h0);
        chk("s6_req_valid",   32'(imem_req_valid), 32'h1);
        chk("s6_req_addr",    imem_req_addr,       32'h0);
        run();
        chk("s6_wait",        32'(instr_valid),    32'h0);
        run();
        chk("s6_restart_pc",  instr_pc,            32'h0);
        chk("s6_restart_ins", instr,               mem_data(32'h0));

        // ---- final report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
